// File: rtl/execute_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_pkg
// Description : Shared opcodes, multiply/divide state encoding and EX/MEM
//               control-bit bundle for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_pkg;

    // Single-cycle ALU operation codes
    localparam logic [4:0] c_ALU_ADD   = 5'h00;
    localparam logic [4:0] c_ALU_ADDU  = 5'h01;
    localparam logic [4:0] c_ALU_SUB   = 5'h02;
    localparam logic [4:0] c_ALU_SUBU  = 5'h03;
    localparam logic [4:0] c_ALU_AND   = 5'h04;
    localparam logic [4:0] c_ALU_OR    = 5'h05;
    localparam logic [4:0] c_ALU_XOR   = 5'h06;
    localparam logic [4:0] c_ALU_NOR   = 5'h07;
    localparam logic [4:0] c_ALU_SLT   = 5'h08;
    localparam logic [4:0] c_ALU_SLTU  = 5'h09;
    localparam logic [4:0] c_ALU_SLL   = 5'h0A;
    localparam logic [4:0] c_ALU_SRL   = 5'h0B;
    localparam logic [4:0] c_ALU_SRA   = 5'h0C;
    localparam logic [4:0] c_ALU_LUI   = 5'h0D;

    // Multiply/divide and HI/LO transfer codes
    localparam logic [4:0] c_ALU_MULT  = 5'h10;
    localparam logic [4:0] c_ALU_MULTU = 5'h11;
    localparam logic [4:0] c_ALU_DIV   = 5'h12;
    localparam logic [4:0] c_ALU_DIVU  = 5'h13;
    localparam logic [4:0] c_ALU_MFHI  = 5'h14;
    localparam logic [4:0] c_ALU_MFLO  = 5'h15;
    localparam logic [4:0] c_ALU_MTHI  = 5'h16;
    localparam logic [4:0] c_ALU_MTLO  = 5'h17;

    // Multiply/divide sequencer states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RUN  = c_ST_RUN,
        ST_FIX  = c_ST_FIX
    } muldiv_state_e;

    // Memory/writeback control bits carried into EX/MEM
    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic reg_write;
    } ex_ctrl_t;

    localparam ex_ctrl_t c_BUBBLE_CTRL = '0;

    // True for every code that touches the HI/LO unit (0x10-0x17)
    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // True for the four codes that launch an iterative operation (0x10-0x13)
    function automatic logic is_start_op(input logic [4:0] op);
        return (op[4:2] == 3'b100);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative 32-step multiply / restoring divide with HI/LO
//               registers. Works on magnitudes, applies signs in FIX.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    muldiv_state_e    r_state;
    logic [4:0]       r_count;
    logic [WIDTH-1:0] r_acc;      // partial product high half / running remainder
    logic [WIDTH-1:0] r_q;        // multiplier being consumed / quotient being built
    logic [WIDTH-1:0] r_m;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_a_raw;    // original dividend, returned as HI on divide-by-zero
    logic             r_is_div;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_b_zero;

    logic             w_signed_op;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign busy = (r_state != ST_IDLE);

    // Operand magnitudes and signs captured at launch (op[0]=1 means unsigned)
    assign w_signed_op = ~op[0];
    assign w_neg_a     = w_signed_op & a[WIDTH-1];
    assign w_neg_b     = w_signed_op & b[WIDTH-1];
    assign w_mag_a     = w_neg_a ? -a : a;
    assign w_mag_b     = w_neg_b ? -b : b;

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        w_add   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
        w_shift = {r_acc, r_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_m});
        w_trial = w_shift[WIDTH-1:0] - r_m;
        if (r_is_div) begin
            w_acc_next = w_ge ? w_trial : w_shift[WIDTH-1:0];
            w_q_next   = {r_q[WIDTH-2:0], w_ge};
        end else begin
            w_acc_next = w_add[WIDTH:1];
            w_q_next   = {w_add[0], r_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX: quotient/product by sign xor, remainder by dividend
    always_comb begin
        w_prod = {r_acc, r_q};
        if (r_neg_a ^ r_neg_b) begin
            w_prod = -w_prod;
        end
        w_quot = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
        w_rem  = r_neg_a ? -r_acc : r_acc;
    end

    // Sequencer and HI/LO registers; results only land in FIX so reset mid-run writes nothing
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= 5'd0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_count  <= 5'd0;
                        r_acc    <= '0;
                        r_q      <= w_mag_a;
                        r_m      <= w_mag_b;
                        r_a_raw  <= a;
                        r_is_div <= op[1];
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_b_zero <= (b == '0);
                    end else begin
                        if (mt_hi) hi <= mt_data;
                        if (mt_lo) lo <= mt_data;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!r_is_div) begin
                        hi <= w_prod[2*WIDTH-1:WIDTH];
                        lo <= w_prod[WIDTH-1:0];
                    end else if (r_b_zero) begin
                        hi <= r_a_raw;
                        lo <= '1;
                    end else begin
                        hi <= w_rem;
                        lo <= w_quot;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : Pipeline execute stage: single-cycle ALU, iterative MUL/DIV
//               with HI/LO, HI/LO hazard stall and the EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import execute_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] store_data,
    input  logic [4:0]       reg_dest,
    input  logic             MemWrite_in,
    input  logic             MemRead_in,
    input  logic             MemToReg_in,
    input  logic             RegWrite_in,
    input  logic [2:0]       trunk_mode_in,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] in_data,
    output logic [4:0]       reg_dest_out,
    output logic [2:0]       trunk_mode,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemToReg_out,
    output logic             RegWrite_out,
    output logic             overflow
);

    logic             w_busy;
    logic             w_accept;
    logic             w_start;
    logic             w_mt_hi;
    logic             w_mt_lo;
    logic             w_ovf;
    logic             w_load_bubble;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    // Any HI/LO-class instruction must wait while the iterative unit is occupied
    assign stall    = w_busy & valid_in & is_hilo_op(alu_op);
    assign w_accept = valid_in & ~flush & ~stall;
    assign w_start  = w_accept & is_start_op(alu_op);
    assign w_mt_hi  = w_accept & (alu_op == c_ALU_MTHI);
    assign w_mt_lo  = w_accept & (alu_op == c_ALU_MTLO);

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;

    // Single-cycle ALU; signed overflow is flagged only for ADD/SUB
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (alu_op)
            c_ALU_ADD: begin
                w_result = w_sum;
                w_ovf    = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            c_ALU_ADDU: w_result = w_sum;
            c_ALU_SUB: begin
                w_result = w_diff;
                w_ovf    = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            c_ALU_SUBU: w_result = w_diff;
            c_ALU_AND:  w_result = operand_a & operand_b;
            c_ALU_OR:   w_result = operand_a | operand_b;
            c_ALU_XOR:  w_result = operand_a ^ operand_b;
            c_ALU_NOR:  w_result = ~(operand_a | operand_b);
            c_ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            c_ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            c_ALU_SLL:  w_result = operand_b << shamt;
            c_ALU_SRL:  w_result = operand_b >> shamt;
            c_ALU_SRA:  w_result = $signed(operand_b) >>> shamt;
            c_ALU_LUI:  w_result = {operand_b[15:0], 16'h0000};
            c_ALU_MFHI: w_result = w_hi;
            c_ALU_MFLO: w_result = w_lo;
            default:    w_result = '0;
        endcase
    end

    // MULT/DIV write no GPR, so they leave a bubble just like overflow/flush/stall
    assign w_load_bubble = ~w_accept | w_ovf | w_start;

    muldiv_unit #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (w_start),
        .op      (alu_op[1:0]),
        .a       (operand_a),
        .b       (operand_b),
        .mt_hi   (w_mt_hi),
        .mt_lo   (w_mt_lo),
        .mt_data (operand_a),
        .hi      (w_hi),
        .lo      (w_lo),
        .busy    (w_busy)
    );

    // EX/MEM pipeline register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            alu_result   <= '0;
            in_data      <= '0;
            reg_dest_out <= '0;
            trunk_mode   <= '0;
            {MemWrite, MemRead, MemToReg_out, RegWrite_out} <= c_BUBBLE_CTRL;
            overflow     <= 1'b0;
        end else if (w_load_bubble) begin
            alu_result   <= '0;
            in_data      <= '0;
            reg_dest_out <= '0;
            trunk_mode   <= '0;
            {MemWrite, MemRead, MemToReg_out, RegWrite_out} <= c_BUBBLE_CTRL;
            overflow     <= w_accept & w_ovf;
        end else begin
            alu_result   <= w_result;
            in_data      <= store_data;
            reg_dest_out <= reg_dest;
            trunk_mode   <= trunk_mode_in;
            MemWrite     <= MemWrite_in;
            MemRead      <= MemRead_in;
            MemToReg_out <= MemToReg_in;
            RegWrite_out <= RegWrite_in;
            overflow     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Self-checking bench for execute_stage. Random and directed
//               instructions are compared against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [4:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  shamt;
    logic [31:0] store_data;
    logic [4:0]  reg_dest;
    logic        MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in;
    logic [2:0]  trunk_mode_in;
    logic        flush;
    logic        stall;
    logic [31:0] alu_result, in_data;
    logic [4:0]  reg_dest_out;
    logic [2:0]  trunk_mode;
    logic        MemWrite, MemRead, MemToReg_out, RegWrite_out, overflow;

    always #5 clock = ~clock;

    execute_stage #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .valid_in      (valid_in),
        .alu_op        (alu_op),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .shamt         (shamt),
        .store_data    (store_data),
        .reg_dest      (reg_dest),
        .MemWrite_in   (MemWrite_in),
        .MemRead_in    (MemRead_in),
        .MemToReg_in   (MemToReg_in),
        .RegWrite_in   (RegWrite_in),
        .trunk_mode_in (trunk_mode_in),
        .flush         (flush),
        .stall         (stall),
        .alu_result    (alu_result),
        .in_data       (in_data),
        .reg_dest_out  (reg_dest_out),
        .trunk_mode    (trunk_mode),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .MemToReg_out  (MemToReg_out),
        .RegWrite_out  (RegWrite_out),
        .overflow      (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: architectural HI/LO and cycles the unit stays occupied
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU from plain integer arithmetic
    task automatic ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output logic [31:0] res, output logic ovf);
        longint sa, sb, s;
        logic [63:0] t;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = 1'b0;
        res = '0;
        case (op)
            5'h00: begin s = sa + sb; t = s; res = t[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'h01: res = a + b;
            5'h02: begin s = sa - sb; t = s; res = t[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'h03: res = a - b;
            5'h04: res = a & b;
            5'h05: res = a | b;
            5'h06: res = a ^ b;
            5'h07: res = ~(a | b);
            5'h08: res = (sa < sb) ? 32'd1 : 32'd0;
            5'h09: res = (a < b) ? 32'd1 : 32'd0;
            5'h0A: res = b * (32'd1 << sh);
            5'h0B: res = b / (32'd1 << sh);
            5'h0C: begin s = sb >>> sh; t = s; res = t[31:0]; end
            5'h0D: res = b * 32'h10000;
            5'h14: res = m_hi;
            5'h15: res = m_lo;
            default: res = '0;
        endcase
    endtask

    // Reference multiply/divide final HI/LO
    task automatic ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p, tq, tr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin q = sa * sb; p = q; end
            2'd1: p = {32'h0, a} * {32'h0, b};
            default: p = '0;
        endcase
        if (op[1] == 1'b0) begin
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            hi = a;
            lo = 32'hFFFFFFFF;
        end else if (op[0] == 1'b0) begin
            q = sa / sb; r = sa % sb; tq = q; tr = r;
            hi = tr[31:0];
            lo = tq[31:0];
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endtask

    // Present one instruction for one cycle and check stall and the EX/MEM load
    task automatic exec(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic fl,
                        input logic [3:0] cb, output logic stalled);
        logic [31:0] sd, res, nhi, nlo;
        logic [4:0]  rd;
        logic [2:0]  tm;
        logic        exp_stall, acc, ovf, bub, hilo, starts;
        sd = $urandom; rd = 5'($urandom); tm = 3'($urandom);
        valid_in = v; alu_op = op; operand_a = a; operand_b = b; shamt = sh;
        store_data = sd; reg_dest = rd; trunk_mode_in = tm; flush = fl;
        {MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in} = cb;
        #1;
        hilo      = (op >= 5'h10) && (op <= 5'h17);
        exp_stall = v && (m_busy > 0) && hilo;
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        acc    = v && !fl && !exp_stall;
        starts = acc && (op >= 5'h10) && (op <= 5'h13);
        ref_alu(op, a, b, sh, res, ovf);
        ref_md(op[1:0], a, b, nhi, nlo);
        bub = !acc || ovf || starts;
        @(posedge clock);
        #1;
        if (m_busy > 0) m_busy--;
        if (starts) begin
            m_hi = nhi; m_lo = nlo; m_busy = 33;
        end
        if (acc && op == 5'h16) m_hi = a;
        if (acc && op == 5'h17) m_lo = a;
        chk("overflow",   {31'b0, overflow},     {31'b0, acc && ovf});
        chk("alu_result", alu_result,            bub ? 32'h0 : res);
        chk("in_data",    in_data,               bub ? 32'h0 : sd);
        chk("reg_dest",   {27'b0, reg_dest_out}, bub ? 32'h0 : {27'b0, rd});
        chk("trunk_mode", {29'b0, trunk_mode},   bub ? 32'h0 : {29'b0, tm});
        chk("ctrl", {28'b0, MemWrite, MemRead, MemToReg_out, RegWrite_out}, bub ? 32'h0 : {28'b0, cb});
        stalled = exp_stall;
    endtask

    // Repeat an MF instruction until it is accepted; returns number of stall cycles
    task automatic wait_mf(input logic [4:0] op, output int nstall);
        logic st;
        nstall = 0;
        for (int i = 0; i < 40; i++) begin
            exec(1'b1, op, $urandom, $urandom, 5'd0, 1'b0, 4'b0101, st);
            if (!st) return;
            nstall++;
        end
        chk("mf_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            chk("rst_result", alu_result, 32'h0);
            chk("rst_misc", {in_data[31:8] | {19'b0, reg_dest_out}, trunk_mode, MemWrite, MemRead, MemToReg_out, RegWrite_out, overflow}, 32'h0);
        end
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0; m_busy = 0;
    endtask

    logic        st;
    int          ns;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  ops[18] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                             5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h1A, 5'h14, 5'h15};
    logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00008000};

    initial begin
        reset_n = 1'b0; valid_in = 1'b1; alu_op = 5'h10; operand_a = 32'h5; operand_b = 32'h3;
        shamt = '0; store_data = 32'hDEAD; reg_dest = 5'd3; trunk_mode_in = 3'd2; flush = 1'b0;
        {MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in} = 4'b1111;
        @(posedge clock);
        #1;
        do_reset(3);
        chk("rst_stall", {31'b0, stall}, 32'h0);

        // Directed ALU points
        exec(1, 5'h00, 32'h7FFFFFFF, 32'h1, 0, 0, 4'b0001, st);
        chk("add_ovf_regwrite", {31'b0, RegWrite_out}, 32'h0);
        exec(1, 5'h01, 32'h7FFFFFFF, 32'h1, 0, 0, 4'b0001, st);
        chk("addu_result", alu_result, 32'h80000000);
        exec(1, 5'h00, 32'h3, 32'h4, 0, 0, 4'b0001, st);
        chk("ovf_one_cycle", {31'b0, overflow}, 32'h0);
        exec(1, 5'h0C, 32'h0, 32'h80000000, 5'd4, 0, 4'b0001, st);
        chk("sra", alu_result, 32'hF8000000);
        exec(1, 5'h08, 32'hFFFFFFFF, 32'h1, 0, 0, 4'b0001, st);
        chk("slt", alu_result, 32'h1);
        exec(1, 5'h09, 32'hFFFFFFFF, 32'h1, 0, 0, 4'b0001, st);
        chk("sltu", alu_result, 32'h0);
        exec(1, 5'h0D, 32'h0, 32'h00001234, 0, 0, 4'b0001, st);
        chk("lui", alu_result, 32'h12340000);
        exec(1, 5'h00, 32'h1, 32'h2, 0, 1, 4'b1111, st);
        chk("flush_bubble", {31'b0, RegWrite_out | MemWrite | MemRead}, 32'h0);

        // Randomized ALU traffic, with occasional flush and idle cycles
        for (int i = 0; i < 150; i++) begin
            rop = ops[$urandom_range(0, 17)];
            ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            exec($urandom_range(0, 7) != 0, rop, ra, rb, 5'($urandom),
                 $urandom_range(0, 7) == 0, 4'($urandom), st);
        end

        // MULT -3 x 7 with dependent MFLO on the next cycle
        exec(1, 5'h10, 32'hFFFFFFFD, 32'h7, 0, 0, 4'b0000, st);
        wait_mf(5'h15, ns);
        chk("mult_stall_cycles", ns, 32'd33);
        chk("mult_lo", alu_result, 32'hFFFFFFEB);
        wait_mf(5'h14, ns);
        chk("mult_hi", alu_result, 32'hFFFFFFFF);

        // Division edge cases
        exec(1, 5'h12, 32'hFFFFFFF9, 32'h2, 0, 0, 4'b0000, st);
        wait_mf(5'h15, ns);
        chk("div_lo", alu_result, 32'hFFFFFFFD);
        wait_mf(5'h14, ns);
        chk("div_hi", alu_result, 32'hFFFFFFFF);
        exec(1, 5'h13, 32'h5, 32'h0, 0, 0, 4'b0000, st);
        wait_mf(5'h15, ns);
        chk("divu0_lo", alu_result, 32'hFFFFFFFF);
        wait_mf(5'h14, ns);
        chk("divu0_hi", alu_result, 32'h5);
        exec(1, 5'h12, 32'h80000000, 32'hFFFFFFFF, 0, 0, 4'b0000, st);
        wait_mf(5'h15, ns);
        chk("divmin_lo", alu_result, 32'h80000000);
        wait_mf(5'h14, ns);
        chk("divmin_hi", alu_result, 32'h0);

        // Random multiply/divide, including a back-to-back MULT that must stall
        for (int i = 0; i < 8; i++) begin
            rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            exec(1, 5'(5'h10 + $urandom_range(0, 3)), $urandom, rb, 0, 0, 4'b0000, st);
            if (i == 3) begin
                exec(1, 5'h11, $urandom, $urandom, 0, 0, 4'b0000, st);
                chk("second_mult_stalls", {31'b0, st}, 32'h1);
            end
            wait_mf(5'h15, ns);
            wait_mf(5'h14, ns);
        end

        // MTHI/MTLO, and a flushed MTHI/MULT that must not take effect
        exec(1, 5'h16, 32'hCAFE0001, 0, 0, 0, 4'b0000, st);
        exec(1, 5'h17, 32'hCAFE0002, 0, 0, 0, 4'b0000, st);
        exec(1, 5'h16, 32'h11111111, 0, 0, 1, 4'b0000, st);
        exec(1, 5'h10, 32'h2, 32'h3, 0, 1, 4'b0000, st);
        wait_mf(5'h14, ns);
        chk("flushed_mult_no_stall", ns, 32'd0);
        chk("mthi", alu_result, 32'hCAFE0001);
        wait_mf(5'h15, ns);
        chk("mtlo", alu_result, 32'hCAFE0002);

        // Independent instructions flow during RUN
        exec(1, 5'h11, $urandom, $urandom, 0, 0, 4'b0000, st);
        for (int i = 0; i < 6; i++) begin
            exec(1, 5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 0, 4'b0001, st);
            chk("indep_no_stall", {31'b0, st}, 32'h0);
        end
        wait_mf(5'h15, ns);
        chk("indep_mf_stall", ns, 32'd27);
        wait_mf(5'h14, ns);

        // Reset during RUN step 10: no result written, HI/LO cleared
        exec(1, 5'h10, 32'h12345678, 32'h9ABCDEF0, 0, 0, 4'b0000, st);
        for (int i = 0; i < 11; i++) exec(0, 5'h00, 0, 0, 0, 0, 4'b0000, st);
        do_reset(1);
        wait_mf(5'h14, ns);
        chk("rst_mid_idle", ns, 32'd0);
        chk("rst_mid_hi", alu_result, 32'h0);
        wait_mf(5'h15, ns);
        chk("rst_mid_lo", alu_result, 32'h0);
        for (int i = 0; i < 40; i++) exec(0, 5'h00, 0, 0, 0, 0, 4'b0000, st);
        wait_mf(5'h14, ns);
        chk("rst_mid_hi_late", alu_result, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
